fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 179 +++++++++++++++++
 tb/tb_fetch_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: keeps at most one code-memory request in flight and
// buffers the returned words as {pc, inst} entries for decode, with redirect flush.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          PC_INCR  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   mem_req,
   output logic [31:0]            mem_addr,
   input  logic                   mem_ready,
   input  logic [31:0]            mem_data,
   output logic                   inst_valid,
   output logic [31:0]            inst_out,
   output logic [31:0]            pc_out,
   input  logic                   inst_ready,
   input  logic                   redirect,
   input  logic [31:0]            redirect_pc,
   output logic [$clog2(DEPTH):0] queue_count
);
   localparam int                 PTR_W    = $clog2(DEPTH);
   localparam int                 CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
   localparam logic [31:0]        INCR     = 32'(PC_INCR);

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_FULL    = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   state_t           state_r, state_next_s;
   logic [31:0]      fetch_pc_r, fetch_pc_next_s;
   logic [31:0]      addr_r, addr_next_s;
   logic [31:0]      target_s;
   logic [PTR_W-1:0] head_r, tail_r, head_next_s, tail_next_s;
   logic [CNT_W-1:0] count_r, count_next_s;
   logic [31:0]      pc_mem_r   [DEPTH];
   logic [31:0]      inst_mem_r [DEPTH];
   logic [31:0]      pc_out_r, inst_out_r;
   logic [31:0]      pc_head_next_s, inst_head_next_s;
   logic             req_s, accept_s, push_s, pop_s;

   // Handshake qualification; a redirect kills both the push and the pop of its cycle.
   always_comb begin
      req_s    = (~reset) & (state_r != ST_FULL);
      accept_s = req_s & mem_ready;
      push_s   = accept_s & (state_r == ST_FETCH) & (~redirect);
      pop_s    = (count_r != '0) & inst_ready & (~redirect);
      target_s = redirect_pc & 32'hFFFF_FFFC;
   end

   // Occupancy/pointer next values and the entry that will be at the head next cycle.
   always_comb begin
      count_next_s     = count_r;
      head_next_s      = head_r;
      tail_next_s      = tail_r;
      pc_head_next_s   = pc_out_r;
      inst_head_next_s = inst_out_r;
      if (redirect) begin
         count_next_s = '0;
         head_next_s  = '0;
         tail_next_s  = '0;
      end else begin
         if (push_s) tail_next_s = tail_r + PTR_ONE;
         else        tail_next_s = tail_r;
         if (pop_s)  head_next_s = head_r + PTR_ONE;
         else        head_next_s = head_r;
         if (push_s && !pop_s)      count_next_s = count_r + CNT_ONE;
         else if (pop_s && !push_s) count_next_s = count_r - CNT_ONE;
         else                       count_next_s = count_r;
      end
      // The slot being written this cycle can itself become the head (empty queue, or pop of the last entry).
      if (push_s && (tail_r == head_next_s)) begin
         pc_head_next_s   = addr_r;
         inst_head_next_s = mem_data;
      end else begin
         pc_head_next_s   = pc_mem_r[head_next_s];
         inst_head_next_s = inst_mem_r[head_next_s];
      end
   end

   // Fetch sequencing: request address, next sequential pc, and stale-response discard.
   always_comb begin
      state_next_s    = state_r;
      fetch_pc_next_s = fetch_pc_r;
      addr_next_s     = addr_r;
      case (state_r)
         ST_FETCH: begin
            if (redirect) begin
               fetch_pc_next_s = target_s;
               if (accept_s) begin
                  addr_next_s  = target_s;
                  state_next_s = ST_FETCH;
               end else begin
                  state_next_s = ST_DISCARD;
               end
            end else if (accept_s) begin
               fetch_pc_next_s = addr_r + INCR;
               addr_next_s     = addr_r + INCR;
               if (count_next_s == FULL_CNT) state_next_s = ST_FULL;
               else                          state_next_s = ST_FETCH;
            end else begin
               state_next_s = ST_FETCH;
            end
         end
         ST_FULL: begin
            if (redirect) begin
               fetch_pc_next_s = target_s;
               addr_next_s     = target_s;
               state_next_s    = ST_FETCH;
            end else if (count_next_s != FULL_CNT) begin
               state_next_s = ST_FETCH;
            end else begin
               state_next_s = ST_FULL;
            end
         end
         ST_DISCARD: begin
            if (redirect) fetch_pc_next_s = target_s;
            else          fetch_pc_next_s = fetch_pc_r;
            if (accept_s) begin
               addr_next_s  = fetch_pc_next_s;
               state_next_s = ST_FETCH;
            end else begin
               state_next_s = ST_DISCARD;
            end
         end
         default: begin
            state_next_s    = ST_FETCH;
            fetch_pc_next_s = fetch_pc_r;
            addr_next_s     = fetch_pc_r;
         end
      endcase
   end

   // Control state, pointers and registered head outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_FETCH;
         fetch_pc_r <= RESET_PC;
         addr_r     <= RESET_PC;
         head_r     <= '0;
         tail_r     <= '0;
         count_r    <= '0;
         pc_out_r   <= 32'h0;
         inst_out_r <= 32'h0;
      end else begin
         state_r    <= state_next_s;
         fetch_pc_r <= fetch_pc_next_s;
         addr_r     <= addr_next_s;
         head_r     <= head_next_s;
         tail_r     <= tail_next_s;
         count_r    <= count_next_s;
         pc_out_r   <= pc_head_next_s;
         inst_out_r <= inst_head_next_s;
      end
   end

   // Entry storage; contents are only observed through the head registers, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push_s) begin
         pc_mem_r[tail_r]   <= addr_r;
         inst_mem_r[tail_r] <= mem_data;
      end
   end

   assign mem_req     = req_s;
   assign mem_addr    = addr_r;
   assign inst_valid  = (count_r != '0);
   assign inst_out    = inst_out_r;
   assign pc_out      = pc_out_r;
   assign queue_count = count_r;

   no_overflow_a: assert property (@(posedge clk) disable iff (reset) !(push_s && (count_r == FULL_CNT)));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic checked by a
// queue-based reference model and a separate output monitor.
module tb_fetch_queue;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        reset, mem_req, mem_ready, inst_valid, inst_ready, redirect;
   logic [31:0] mem_addr, mem_data, inst_out, pc_out, redirect_pc;
   logic [2:0]  queue_count;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   // reference model state: occupancy, next sequential pc, pending stale request
   entry_t      sb[$];
   int          occ = 0;
   logic [31:0] next_pc = RESET_PC;
   logic [31:0] stale_addr = 32'h0;
   logic        stale = 1'b0;
   logic        m_req, m_acc, m_pop;
   logic        rst_prev = 1'b0;
   entry_t      got;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   assign mem_data = mem_ready ? word_at(mem_addr) : ~word_at(mem_addr);

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_INCR(4)) dut (
      .clk(clk), .reset(reset),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
      .inst_valid(inst_valid), .inst_out(inst_out), .pc_out(pc_out), .inst_ready(inst_ready),
      .redirect(redirect), .redirect_pc(redirect_pc), .queue_count(queue_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic cyc(input logic rst, input logic mr, input logic ir, input logic rd, input logic [31:0] rpc);
      @(negedge clk);
      reset       = rst;
      mem_ready   = mr;
      inst_ready  = ir;
      redirect    = rd;
      redirect_pc = rpc;
      #1;
   endtask

   // Monitor: compares DUT outputs with the model state at the start of each cycle.
   always @(negedge clk) begin
      #2;
      if (reset) begin
         check("rst_mem_req", 32'(mem_req), 32'h0);
         if (rst_prev) begin
            check("rst_mem_addr", mem_addr, RESET_PC);
            check("rst_inst_valid", 32'(inst_valid), 32'h0);
            check("rst_count", 32'(queue_count), 32'h0);
            check("rst_pc_out", pc_out, 32'h0);
            check("rst_inst_out", inst_out, 32'h0);
         end
      end else begin
         check("mem_req", 32'(mem_req), 32'(occ != DEPTH));
         if (mem_req) check("mem_addr", mem_addr, stale ? stale_addr : next_pc);
         check("inst_valid", 32'(inst_valid), 32'(occ != 0));
         check("queue_count", 32'(queue_count), 32'(occ));
         if (inst_valid && inst_ready && !redirect) begin
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL pop_empty: DUT popped pc 0x%08h, scoreboard holds no entry at %0t", pc_out, $time);
            end else begin
               got = sb.pop_front();
               check("sb_pc", pc_out, got.pc);
               check("sb_inst", inst_out, got.inst);
            end
         end
      end
      rst_prev = reset;
   end

   // Reference model: a fetch stream that restarts on redirect, feeding a bounded queue.
   always @(negedge clk) begin
      #3;
      if (reset) begin
         occ     = 0;
         sb.delete();
         next_pc = RESET_PC;
         stale   = 1'b0;
      end else begin
         m_req = (occ != DEPTH);
         m_acc = m_req && mem_ready;
         m_pop = !redirect && (occ != 0) && inst_ready;
         if (redirect) begin
            occ = 0;
            sb.delete();
            if (m_acc) stale = 1'b0;
            else if (m_req && !stale) begin
               stale      = 1'b1;
               stale_addr = next_pc;
            end
            next_pc = redirect_pc & 32'hFFFF_FFFC;
         end else begin
            if (m_pop) occ--;
            if (m_acc) begin
               if (stale) stale = 1'b0;
               else begin
                  sb.push_back('{pc: next_pc, inst: word_at(next_pc)});
                  occ++;
                  next_pc = next_pc + 32'd4;
               end
            end
         end
      end
   end

   logic        r_mr, r_ir, r_rd;
   logic [31:0] r_rpc;
   int          bias;

   initial begin
      reset = 1'b1; mem_ready = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      check("d_reset_count", 32'(queue_count), 32'h0);
      check("d_reset_req", 32'(mem_req), 32'h0);

      // streaming at full rate
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
         check("d_stream_addr", mem_addr, 32'(4 * i));
         if (i > 0) begin
            check("d_stream_pc", pc_out, 32'(4 * (i - 1)));
            check("d_stream_inst", inst_out, word_at(32'(4 * (i - 1))));
         end
      end

      // fill to DEPTH, then release one slot
      repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      repeat (6) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check("d_full_count", 32'(queue_count), 32'd4);
      check("d_full_req", 32'(mem_req), 32'h0);
      check("d_full_pc", pc_out, 32'h0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check("d_resume_count", 32'(queue_count), 32'd3);
      check("d_resume_req", 32'(mem_req), 32'h1);
      check("d_resume_addr", mem_addr, 32'h10);
      check("d_resume_pc", pc_out, 32'h4);

      // redirect while a request is stalled: stale response dropped
      repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h103);
      check("d_disc_addr0", mem_addr, 32'h8);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check("d_disc_addr1", mem_addr, 32'h8);
      check("d_disc_valid", 32'(inst_valid), 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check("d_disc_addr2", mem_addr, 32'h8);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check("d_disc_next", mem_addr, 32'h100);
      check("d_disc_empty", 32'(queue_count), 32'h0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check("d_disc_pc", pc_out, 32'h100);
      check("d_disc_inst", inst_out, word_at(32'h100));

      // redirect coincident with accept and pop
      repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
      check("d_racc_addr", mem_addr, 32'hC);
      check("d_racc_pc", pc_out, 32'h8);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check("d_racc_count", 32'(queue_count), 32'h0);
      check("d_racc_valid", 32'(inst_valid), 32'h0);
      check("d_racc_next", mem_addr, 32'h40);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check("d_racc_pc2", pc_out, 32'h40);

      // reset with queued entries and a pending request
      repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check("d_mid_count", 32'(queue_count), 32'd3);
      check("d_mid_addr", mem_addr, 32'hC);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      check("d_mid_rst_req", 32'(mem_req), 32'h0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      check("d_mid_rst_count", 32'(queue_count), 32'h0);
      check("d_mid_rst_valid", 32'(inst_valid), 32'h0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      check("d_mid_refetch_req", 32'(mem_req), 32'h1);
      check("d_mid_refetch_addr", mem_addr, RESET_PC);

      // randomized traffic with sparse redirects, including one near the address wrap
      for (int i = 0; i < 10000; i++) begin
         bias = (i / 400) % 3;
         if (bias == 0)      r_ir = ($urandom_range(0, 7) == 0);
         else if (bias == 1) r_ir = ($urandom_range(0, 1) == 1);
         else                r_ir = ($urandom_range(0, 7) != 0);
         r_mr  = ($urandom_range(0, 3) != 0);
         r_rd  = ($urandom_range(0, 47) == 0) || (i == 5000);
         r_rpc = (i == 5000) ? 32'hFFFF_FFF5 : $urandom();
         cyc(1'b0, r_mr, r_ir, r_rd, r_rpc);
      end
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
